// File: rtl/sspi_burst.sv
// Serial-to-Wishbone burst bridge. The host frames LSB-first commands on spi_clk/spi_mosi and the block issues Wishbone master cycles.
// Define SSPI_TIMEOUT_EN to force a stalled WB cycle to complete as an error after TIMEOUT cycles.
module sspi_burst #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  spi_clk,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic [ADDR_W-1:0]     wb_adr,
    output logic [DATA_W-1:0]     wb_o_dat,
    input  logic [DATA_W-1:0]     wb_i_dat,
    output logic                  wb_we,
    output logic [DATA_W/8-1:0]   wb_sel,
    input  logic                  wb_ack,
    input  logic                  wb_err,
    output logic                  busy
);

    // state    | meaning
    // IDLE     | waiting for a start bit (mosi=0), miso=1
    // ADDR     | shifting in the start word address
    // LEN      | shifting in the burst length (words-1)
    // RW       | sampling the direction bit (1=write)
    // WR_DAT   | shifting in one write word
    // WB_REQ   | launching the Wishbone cycle
    // WAIT     | cycle in flight; miso=1 until done, then 0 marker
    // RD_DAT   | shifting the read word out on miso
    // STATUS   | one edge of error status, then next word or IDLE
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_ADDR   = 4'd1;
    localparam logic [3:0] S_LEN    = 4'd2;
    localparam logic [3:0] S_RW     = 4'd3;
    localparam logic [3:0] S_WR_DAT = 4'd4;
    localparam logic [3:0] S_WB_REQ = 4'd5;
    localparam logic [3:0] S_WAIT   = 4'd6;
    localparam logic [3:0] S_RD_DAT = 4'd7;
    localparam logic [3:0] S_STATUS = 4'd8;

    localparam int MAX_W = (ADDR_W > DATA_W) ? ((ADDR_W > LEN_W) ? ADDR_W : LEN_W)
                                             : ((DATA_W > LEN_W) ? DATA_W : LEN_W);
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    if ((DATA_W % 8) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("sspi_burst: DATA_W must be a multiple of 8 and TIMEOUT at least 1");
    end

    logic [2:0]        sclk_q, sclk_d;
    logic [1:0]        mosi_q, mosi_d;
    logic [3:0]        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              miso_q, miso_d;
    logic              cyc_q, cyc_d;
    logic [ADDR_W-1:0] wb_adr_q, wb_adr_d;
    logic [DATA_W-1:0] wb_dat_q, wb_dat_d;
    logic              wb_we_q, wb_we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              sample;
    logic              bit_in;

`ifdef SSPI_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // mosi is delayed to line up with the synchronised clock edge
    assign sample = sclk_q[1] & ~sclk_q[2];
    assign bit_in = mosi_q[1];

    always_comb begin
        sclk_d     = {sclk_q[1:0], spi_clk};
        mosi_d     = {mosi_q[0], spi_mosi};
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        addr_d     = addr_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        we_d       = we_q;
        shreg_d    = shreg_q;
        miso_d     = miso_q;
        cyc_d      = cyc_q;
        wb_adr_d   = wb_adr_q;
        wb_dat_d   = wb_dat_q;
        wb_we_d    = wb_we_q;
        done_d     = done_q;
        err_d      = err_q;
`ifdef SSPI_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sample) begin
                    miso_d = 1'b1;
                    if (!bit_in) begin
                        state_d    = S_ADDR;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                    end
                end
            end
            S_ADDR: begin
                if (sample) begin
                    miso_d = 1'b1;
                    addr_d = (addr_q >> 1) | (ADDR_W'(bit_in) << (ADDR_W - 1));
                    if (bit_cnt_q == ADDR_LAST) begin
                        state_d   = S_LEN;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_LEN: begin
                if (sample) begin
                    miso_d = 1'b1;
                    len_d  = (len_q >> 1) | (LEN_W'(bit_in) << (LEN_W - 1));
                    if (bit_cnt_q == LEN_LAST) begin
                        state_d   = S_RW;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_RW: begin
                if (sample) begin
                    miso_d    = 1'b1;
                    we_d      = bit_in;
                    bit_cnt_d = '0;
                    state_d   = bit_in ? S_WR_DAT : S_WB_REQ;
                end
            end
            S_WR_DAT: begin
                if (sample) begin
                    miso_d  = 1'b1;
                    shreg_d = (shreg_q >> 1) | (DATA_W'(bit_in) << (DATA_W - 1));
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d   = S_WB_REQ;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_WB_REQ: begin
                cyc_d    = 1'b1;
                wb_adr_d = addr_q;
                wb_dat_d = shreg_q;
                wb_we_d  = we_q;
                done_d   = 1'b0;
                err_d    = 1'b0;
`ifdef SSPI_TIMEOUT_EN
                tmo_d    = TMO_LOAD;
`endif
                state_d  = S_WAIT;
                if (sample) begin
                    miso_d = 1'b1;
                end
            end
            S_WAIT: begin
                // err wins over ack when both arrive together
                if (cyc_q && (wb_ack || wb_err)) begin
                    cyc_d  = 1'b0;
                    done_d = 1'b1;
                    err_d  = wb_err;
                    if (!wb_we_q) begin
                        shreg_d = wb_i_dat;
                    end
                end
`ifdef SSPI_TIMEOUT_EN
                else if (cyc_q) begin
                    if (tmo_q == TMO_W'(1)) begin
                        cyc_d  = 1'b0;
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        tmo_d = tmo_q - 1'b1;
                    end
                end
`endif
                if (sample) begin
                    if (!done_q) begin
                        miso_d = 1'b1;
                    end else begin
                        miso_d    = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = wb_we_q ? S_STATUS : S_RD_DAT;
                    end
                end
            end
            S_RD_DAT: begin
                if (sample) begin
                    miso_d  = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d   = S_STATUS;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_STATUS: begin
                if (sample) begin
                    miso_d = err_q;
                    if (err_q || (word_cnt_q == len_q)) begin
                        state_d = S_IDLE;
                    end else begin
                        addr_d     = addr_q + 1'b1;
                        word_cnt_d = word_cnt_q + 1'b1;
                        bit_cnt_d  = '0;
                        state_d    = we_q ? S_WR_DAT : S_WB_REQ;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // synchroniser resets high so a host clock already low at release gives no edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sclk_q     <= '1;
            mosi_q     <= '1;
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            we_q       <= 1'b0;
            shreg_q    <= '0;
            miso_q     <= 1'b1;
            cyc_q      <= 1'b0;
            wb_adr_q   <= '0;
            wb_dat_q   <= '0;
            wb_we_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            we_q       <= we_d;
            shreg_q    <= shreg_d;
            miso_q     <= miso_d;
            cyc_q      <= cyc_d;
            wb_adr_q   <= wb_adr_d;
            wb_dat_q   <= wb_dat_d;
            wb_we_q    <= wb_we_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign spi_miso = miso_q;
    assign wb_cyc   = cyc_q;
    assign wb_stb   = cyc_q;
    assign wb_adr   = wb_adr_q;
    assign wb_o_dat = wb_dat_q;
    assign wb_we    = wb_we_q;
    assign wb_sel   = '1;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_sspi_burst.sv
// Directed bench for sspi_burst: host bit-bangs frames, a small Wishbone slave answers and logs cycles.
module tb_sspi_burst;
    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 16;
    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 8;
`ifdef SSPI_TIMEOUT_EN
    localparam int SLOW_DLY  = 5;
    localparam int SLOW_ONES = 0;
`else
    localparam int SLOW_DLY  = 20;
    localparam int SLOW_ONES = 2;
`endif

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              spi_clk;
    logic              spi_mosi;
    logic              spi_miso;
    logic              wb_cyc;
    logic              wb_stb;
    logic [ADDR_W-1:0] wb_adr;
    logic [DATA_W-1:0] wb_o_dat;
    logic [DATA_W-1:0] wb_i_dat;
    logic              wb_we;
    logic [1:0]        wb_sel;
    logic              wb_ack;
    logic              wb_err;
    logic              busy;

    sspi_burst #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_adr(wb_adr), .wb_o_dat(wb_o_dat), .wb_i_dat(wb_i_dat),
        .wb_we(wb_we), .wb_sel(wb_sel), .wb_ack(wb_ack), .wb_err(wb_err), .busy(busy)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // slave configuration (written by the main process only)
    int          ack_delay = 3;
    bit          slv_hang  = 1'b0;
    bit          resp_err  [32];
    bit          resp_both [32];
    logic [15:0] resp_dat  [32];

    // slave bookkeeping (written by the slave process only)
    int          n_log = 0;
    int          n_resp = 0;
    int          slv_cnt = 0;
    int          cyc_hi_cnt = 0;
    logic [23:0] log_adr [32];
    logic [15:0] log_dat [32];
    logic        log_we  [32];
    logic [1:0]  log_sel [32];

    initial begin
        for (int i = 0; i < 32; i++) begin
            resp_err[i]  = 1'b0;
            resp_both[i] = 1'b0;
            resp_dat[i]  = 16'h0000;
        end
    end

    initial begin : wb_slave
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        wb_i_dat = '0;
        forever begin
            @(negedge i_clk);
            wb_ack = 1'b0;
            wb_err = 1'b0;
            if (wb_cyc) begin
                cyc_hi_cnt++;
                if (slv_cnt == 0) begin
                    if (n_log < 32) begin
                        log_adr[n_log] = wb_adr;
                        log_dat[n_log] = wb_o_dat;
                        log_we[n_log]  = wb_we;
                        log_sel[n_log] = wb_sel;
                    end
                    n_log++;
                end
                slv_cnt++;
                if (!slv_hang && slv_cnt == ack_delay && n_resp < 32) begin
                    wb_err   = resp_err[n_resp];
                    wb_ack   = !resp_err[n_resp] || resp_both[n_resp];
                    wb_i_dat = resp_dat[n_resp];
                    n_resp++;
                end
            end else begin
                slv_cnt = 0;
            end
        end
    end

    // one host bit: mosi set, 4 clocks low, rise, 4 clocks high, sample miso, fall
    task automatic spi_bit(input logic b, output logic m);
        spi_mosi = b;
        repeat (4) @(negedge i_clk);
        spi_clk = 1'b1;
        repeat (4) @(negedge i_clk);
        m = spi_miso;
        spi_clk = 1'b0;
    endtask

    task automatic send_hdr(input logic [23:0] adr, input logic [3:0] len, input logic rw);
        logic m;
        spi_bit(1'b0, m);
        for (int i = 0; i < ADDR_W; i++) spi_bit(adr[i], m);
        for (int i = 0; i < LEN_W; i++) spi_bit(len[i], m);
        spi_bit(rw, m);
    endtask

    task automatic send_word(input logic [15:0] d);
        logic m;
        for (int i = 0; i < DATA_W; i++) spi_bit(d[i], m);
    endtask

    task automatic read_word(output logic [15:0] d);
        logic m;
        d = '0;
        for (int i = 0; i < DATA_W; i++) begin
            spi_bit(1'b1, m);
            d[i] = m;
        end
    endtask

    task automatic wait_marker(input string tag, output int ones);
        logic m;
        bit   found;
        ones  = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            spi_bit(1'b1, m);
            if (m == 1'b0) found = 1'b1;
            else ones++;
        end
        check_eq({tag, "_marker"}, {31'd0, found}, 32'd1);
    endtask

    task automatic get_status(input string tag, input logic exp);
        logic m;
        spi_bit(1'b1, m);
        check_eq({tag, "_status"}, {31'd0, m}, {31'd0, exp});
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          b;
        int          r;
        int          ones;
        logic        m;
        logic [15:0] d;
        logic [15:0] rd_exp [4];

        i_rst    = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 1'b1;
        repeat (5) @(negedge i_clk);
        check_eq("rst_miso", {31'd0, spi_miso}, 32'd1);
        check_eq("rst_cyc", {31'd0, wb_cyc}, 32'd0);
        check_eq("rst_stb", {31'd0, wb_stb}, 32'd0);
        check_eq("rst_we", {31'd0, wb_we}, 32'd0);
        check_eq("rst_adr", {8'd0, wb_adr}, 32'd0);
        check_eq("rst_odat", {16'd0, wb_o_dat}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);

        // single write, ack after 3 clocks
        b = n_log;
        ack_delay = 3;
        send_hdr(24'h000123, 4'd0, 1'b1);
        check_eq("w1_busy", {31'd0, busy}, 32'd1);
        send_word(16'hBEEF);
        wait_marker("w1", ones);
        check_eq("w1_wait_ones", ones, 32'd0);
        get_status("w1", 1'b0);
        check_eq("w1_busy_end", {31'd0, busy}, 32'd0);
        spi_bit(1'b1, m);
        check_eq("w1_idle_miso", {31'd0, m}, 32'd1);
        check_eq("w1_ncyc", n_log - b, 32'd1);
        check_eq("w1_adr", {8'd0, log_adr[b]}, 32'h000123);
        check_eq("w1_dat", {16'd0, log_dat[b]}, 32'h0000BEEF);
        check_eq("w1_we", {31'd0, log_we[b]}, 32'd1);
        check_eq("w1_sel", {30'd0, log_sel[b]}, 32'd3);

        // read burst of 4 across the address wrap
        b = n_log;
        r = n_resp;
        rd_exp[0] = 16'h1111; rd_exp[1] = 16'h2222; rd_exp[2] = 16'h3333; rd_exp[3] = 16'h4444;
        for (int i = 0; i < 4; i++) resp_dat[r + i] = rd_exp[i];
        ack_delay = 5;
        send_hdr(24'hFFFFFE, 4'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_marker($sformatf("rb%0d", i), ones);
            read_word(d);
            check_eq($sformatf("rb%0d_data", i), {16'd0, d}, {16'd0, rd_exp[i]});
            get_status($sformatf("rb%0d", i), 1'b0);
        end
        check_eq("rb_busy_end", {31'd0, busy}, 32'd0);
        check_eq("rb_ncyc", n_log - b, 32'd4);
        check_eq("rb_adr0", {8'd0, log_adr[b]}, 32'hFFFFFE);
        check_eq("rb_adr1", {8'd0, log_adr[b + 1]}, 32'hFFFFFF);
        check_eq("rb_adr2", {8'd0, log_adr[b + 2]}, 32'h000000);
        check_eq("rb_adr3", {8'd0, log_adr[b + 3]}, 32'h000001);
        check_eq("rb_we", {31'd0, log_we[b + 2]}, 32'd0);

        // write burst of 3, slave errors on the second word
        b = n_log;
        r = n_resp;
        resp_err[r + 1] = 1'b1;
        ack_delay = 3;
        send_hdr(24'h000040, 4'd2, 1'b1);
        send_word(16'hA5A5);
        wait_marker("wb0", ones);
        get_status("wb0", 1'b0);
        send_word(16'h5A5A);
        wait_marker("wb1", ones);
        get_status("wb1", 1'b1);
        check_eq("wb_busy_end", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 20; i++) spi_bit(1'b1, m);
        check_eq("wb_ncyc", n_log - b, 32'd2);
        check_eq("wb_adr1", {8'd0, log_adr[b + 1]}, 32'h000041);
        check_eq("wb_dat1", {16'd0, log_dat[b + 1]}, 32'h00005A5A);

        // read with ack and err together
        r = n_resp;
        resp_err[r]  = 1'b1;
        resp_both[r] = 1'b1;
        resp_dat[r]  = 16'hC3A5;
        send_hdr(24'h000777, 4'd0, 1'b0);
        wait_marker("ae", ones);
        read_word(d);
        check_eq("ae_data", {16'd0, d}, 32'h0000C3A5);
        get_status("ae", 1'b1);
        check_eq("ae_busy_end", {31'd0, busy}, 32'd0);

        // reset while a read cycle is stalled
        slv_hang = 1'b1;
        send_hdr(24'h000010, 4'd1, 1'b0);
        repeat (2) @(negedge i_clk);
        check_eq("rs_cyc_before", {31'd0, wb_cyc}, 32'd1);
        i_rst = 1'b1;
        @(negedge i_clk);
        check_eq("rs_cyc", {31'd0, wb_cyc}, 32'd0);
        check_eq("rs_stb", {31'd0, wb_stb}, 32'd0);
        check_eq("rs_miso", {31'd0, spi_miso}, 32'd1);
        check_eq("rs_busy", {31'd0, busy}, 32'd0);
        i_rst = 1'b0;
        slv_hang = 1'b0;
        repeat (4) @(negedge i_clk);

        // fresh write after reset, slow slave
        b = n_log;
        ack_delay = SLOW_DLY;
        send_hdr(24'h000200, 4'd0, 1'b1);
        send_word(16'h1234);
        wait_marker("fw", ones);
        check_eq("fw_wait_ones", ones, SLOW_ONES);
        get_status("fw", 1'b0);
        check_eq("fw_ncyc", n_log - b, 32'd1);
        check_eq("fw_adr", {8'd0, log_adr[b]}, 32'h000200);
        check_eq("fw_dat", {16'd0, log_dat[b]}, 32'h00001234);

`ifdef SSPI_TIMEOUT_EN
        // slave never answers: cycle times out after TIMEOUT clocks
        b = cyc_hi_cnt;
        slv_hang = 1'b1;
        send_hdr(24'h000300, 4'd0, 1'b0);
        wait_marker("to", ones);
        read_word(d);
        get_status("to", 1'b1);
        check_eq("to_cyc_len", cyc_hi_cnt - b, TIMEOUT);
        check_eq("to_cyc_end", {31'd0, wb_cyc}, 32'd0);
        check_eq("to_busy_end", {31'd0, busy}, 32'd0);
        slv_hang = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
